mult_seq_ctrl: RTL and testbench
================================

# mult_seq_ctrl

Multi-cycle sequencer wrapped around the combinational `array_multiplier` in the ALU multiply path. It accepts operands from the execute stage with a valid/ready handshake and converts signed operands to magnitudes. It holds them stable at the multiplier for a fixed settle window, then sign-corrects the 2·WIDTH product and presents it as HI/LO to writeback under a second valid/ready handshake.

## Interface
- `WIDTH`, 32, operand width; product is 2·WIDTH.
- `MUL_CYCLES`, 4, settle cycles allowed for the combinational multiplier; legal range 1..255.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start_valid`  in  1  operands and mode valid.
- `start_ready`  out  1  sequencer can accept; high only in IDLE and not in reset.
- `is_signed`  in  1  1 = two's-complement multiply, 0 = unsigned.
- `op_a`  in  WIDTH  multiplicand.
- `op_b`  in  WIDTH  multiplier.
- `res_valid`  out  1  `res_hi`/`res_lo` hold a finished product.
- `res_ready`  in  1  writeback consumes the result.
- `res_hi`  out  WIDTH  product bits [2·WIDTH-1:WIDTH].
- `res_lo`  out  WIDTH  product bits [WIDTH-1:0].
- `busy`  out  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE.
- IDLE:
  - On `start_valid && start_ready`, latch the multiplier inputs:
    - `mag_a` = `is_signed && op_a[WIDTH-1]` ? −`op_a` : `op_a`; `mag_b` likewise.
    - `neg` = `is_signed && (op_a[MSB] ^ op_b[MSB])`.
    - Load `cnt` = `MUL_CYCLES`−1.
  - Go to CALC.
- CALC:
  - `mag_a`/`mag_b` stay stable at the multiplier inputs.
  - If `cnt` != 0, decrement.
  - If `cnt` == 0, register `res` = `neg` ? −`prod` : `prod` (2·WIDTH-bit two's-complement negate) and go to DONE.
- DONE:
  - `res_valid` = 1; result registers are frozen.
  - On `res_ready`, go to IDLE. No new operands are accepted in the same cycle.
- Width rules: the magnitude of −2^(WIDTH−1) is 2^(WIDTH−1), which fits unsigned WIDTH bits. The product never overflows 2·WIDTH bits. Negating 0 yields 0.
- `start_valid` is ignored outside IDLE. Operand inputs are don't-care after the accepting edge.
- `res_ready` is ignored outside DONE.

## Timing
- Reset values: `start_ready`=0 while `rst` is high, then 1; `res_valid`=0; `busy`=0; `res_hi`=`res_lo`=0; `cnt`=0.
- Latency: `res_valid` rises exactly `MUL_CYCLES`+1 rising edges after the accepting edge, counting the capture edge.
- Throughput: `MUL_CYCLES`+2 cycles per operation when `res_ready` is held high.
- `res_valid` stays asserted with stable data until the `res_ready` edge. It deasserts the cycle after that edge; `start_ready` asserts in the same cycle.
- `rst` asserted in CALC or DONE: the next edge returns to IDLE, clears the outputs and drops the in-flight result. No partial result is ever presented.
- `rst` and `start_valid` asserted together: reset wins and nothing is accepted.
- The multiplier path is a multicycle path of `MUL_CYCLES` from the `mag` registers to the `res` registers. Constraints are set accordingly.

## Structure
- Shared definitions header `mult_defs`: state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the default WIDTH/`MUL_CYCLES` constants, reused by the ALU decode.
- One sub-module: the existing `array_multiplier`, instantiated with `width`=WIDTH and fed from `mag_a`/`mag_b`.
- Sign conversion and the counter stay inline.

## Test plan
- Unsigned: `op_a`=0xFFFFFFFF, `op_b`=0xFFFFFFFF, `is_signed`=0 → `res_hi`=0xFFFFFFFE, `res_lo`=0x00000001, `res_valid` rising 5 edges after accept (`MUL_CYCLES`=4).
- Signed mixed: −3 × 7 (0xFFFFFFFD, 0x00000007) → `res_hi`=0xFFFFFFFF, `res_lo`=0xFFFFFFEB.
- Signed corner: 0x80000000 × 0x80000000 → `res_hi`=0x40000000, `res_lo`=0; and 0x80000000 × 0x00000000 → all zero.
- Backpressure: hold `res_ready`=0 for 10 cycles after `res_valid` → outputs stable, `start_ready`=0 and a pulsed `start_valid` ignored. Then `res_ready`=1 → `res_valid`=0 and `start_ready`=1 next cycle.
- Reset mid-CALC: assert `rst` two cycles after accept → next cycle `busy`=0, `res_valid`=0, results 0. The next operation, 6×7, yields `res_lo`=42.
- `MUL_CYCLES`=1 build: back-to-back operations with `res_ready` tied high → one result every 3 cycles, values match a reference model over 1000 random signed/unsigned pairs.

Source files
------------

// File: rtl/mult_seq_ctrl_pkg.sv
// Shared multiply-path definitions: sequencer state encodings and default sizing,
// also used by the ALU decode.
package mult_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_MUL_CYCLES = 4;
    localparam int CNT_W          = 8;

endpackage

// File: rtl/mult_seq_ctrl_array_multiplier.sv
// Purely combinational unsigned array multiplier: one shifted partial product
// per multiplier bit, accumulated down a ripple chain.
module array_multiplier #(
    parameter int width = 32
) (
    input  logic [width-1:0]   a_i,
    input  logic [width-1:0]   b_i,
    output logic [2*width-1:0] prod_o
);

    logic [2*width-1:0] sum_w [0:width];
    logic [2*width-1:0] a_ext_w;

    assign a_ext_w  = {{width{1'b0}}, a_i};
    assign sum_w[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < width; gi++) begin : g_row
            logic [2*width-1:0] pp_w;
            assign pp_w          = b_i[gi] ? (a_ext_w << gi) : '0;
            assign sum_w[gi + 1] = sum_w[gi] + pp_w;
        end
    endgenerate

    assign prod_o = sum_w[width];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle sequencer around the combinational array multiplier: captures
// operand magnitudes, waits a fixed settle window, then sign-corrects the product.
module mult_seq_ctrl
    import mult_defs::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             busy
);

    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    mult_state_e         state_q, state_d;
    logic [WIDTH-1:0]    mag_a_q, mag_b_q;
    logic [WIDTH-1:0]    mag_a_d, mag_b_d;
    logic                neg_q, neg_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*WIDTH-1:0]  res_q;
    logic [2*WIDTH-1:0]  prod_w;
    logic [2*WIDTH-1:0]  res_d;
    logic                accept_w;

    assign accept_w = start_valid && start_ready;

    always_comb begin
        mag_a_d = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
        mag_b_d = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
        neg_d   = is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        res_d   = neg_q ? ((~prod_w) + ONE_2W) : prod_w;
    end

    // mag registers only change on accept, so the multiplier sees stable inputs for the whole CALC window
    array_multiplier #(
        .width (WIDTH)
    ) u_array_multiplier (
        .a_i    (mag_a_q),
        .b_i    (mag_b_q),
        .prod_o (prod_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept_w) begin
                mag_a_q <= mag_a_d;
                mag_b_q <= mag_b_d;
                neg_q   <= neg_d;
                cnt_q   <= CNT_LOAD;
            end else if (state_q == ST_CALC) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    res_q <= res_d;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_w)       state_d = ST_CALC;
            ST_CALC: if (cnt_q == '0)    state_d = ST_DONE;
            ST_DONE: if (res_ready)      state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state_q == ST_IDLE) && !rst;
        res_valid   = (state_q == ST_DONE);
        busy        = (state_q == ST_CALC) || (state_q == ST_DONE);
        res_hi      = res_q[2*WIDTH-1:WIDTH];
        res_lo      = res_q[WIDTH-1:0];
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: a MUL_CYCLES=4 instance for directed cases
// and a MUL_CYCLES=1 instance for back-to-back random traffic.
module tb_mult_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, rst1;
    logic        start_valid, start_valid1;
    logic        start_ready, start_ready1;
    logic        is_signed, is_signed1;
    logic [31:0] op_a, op_b, op_a1, op_b1;
    logic        res_valid, res_valid1;
    logic        res_ready, res_ready1;
    logic [31:0] res_hi, res_lo, res_hi1, res_lo1;
    logic        busy, busy1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [63:0] exp_q0 [$];
    logic [63:0] exp_q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_seq_ctrl #(.WIDTH(32), .MUL_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .is_signed(is_signed), .op_a(op_a), .op_b(op_b), .res_valid(res_valid),
        .res_ready(res_ready), .res_hi(res_hi), .res_lo(res_lo), .busy(busy)
    );

    mult_seq_ctrl #(.WIDTH(32), .MUL_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1), .start_valid(start_valid1), .start_ready(start_ready1),
        .is_signed(is_signed1), .op_a(op_a1), .op_b(op_b1), .res_valid(res_valid1),
        .res_ready(res_ready1), .res_hi(res_hi1), .res_lo(res_lo1), .busy(busy1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q0.size() == 0) check("dut0_unexpected_result", {res_hi, res_lo}, 64'h0);
            else check("dut0_result", {res_hi, res_lo}, exp_q0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst1 && res_valid1 && res_ready1) begin
            if (exp_q1.size() == 0) check("dut1_unexpected_result", {res_hi1, res_lo1}, 64'h0);
            else check("dut1_result", {res_hi1, res_lo1}, exp_q1.pop_front());
        end
    end

    // Caller sits at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input bit push);
        int n = 0;
        while (!start_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("issue_start_ready", {63'b0, start_ready}, 64'h1);
        op_a = a; op_b = b; is_signed = s; start_valid = 1'b1;
        if (push) exp_q0.push_back(exp);
        @(posedge clk); #1;
        start_valid = 1'b0;
        op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D; is_signed = ~s;
    endtask

    task automatic wait_valid(input string name);
        int n = 1;
        while (!res_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check(name, 64'(n), 64'd5);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] held;
        int last_acc;
        rst = 1'b1; rst1 = 1'b1;
        start_valid = 1'b0; start_valid1 = 1'b0;
        is_signed = 1'b0; is_signed1 = 1'b0;
        op_a = '0; op_b = '0; op_a1 = '0; op_b1 = '0;
        res_ready = 1'b1; res_ready1 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        start_valid = 1'b1;
        @(posedge clk); #1;
        check("rst_start_ready", {63'b0, start_ready}, 64'h0);
        check("rst_outputs", {61'b0, res_valid, busy, |{res_hi, res_lo}}, 64'h0);
        start_valid = 1'b0;
        rst = 1'b0; rst1 = 1'b0;
        @(posedge clk); #1;
        check("post_rst_start_ready", {63'b0, start_ready}, 64'h1);
        check("post_rst_busy", {63'b0, busy}, 64'h0);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
        wait_valid("lat_unsigned_max");
        issue(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
        wait_valid("lat_signed_mixed");
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1);
        wait_valid("lat_signed_min_sq");
        issue(32'h8000_0000, 32'h0000_0000, 1'b1, 64'h0, 1'b1);
        wait_valid("lat_signed_min_zero");
        issue(32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000, 1'b1);
        wait_valid("lat_unsigned_carry");
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1, 1'b1);
        wait_valid("lat_signed_neg1_sq");

        // Backpressure: result must sit frozen while writeback stalls.
        @(posedge clk); #1;
        res_ready = 1'b0;
        issue(32'h1234_5678, 32'h0000_000A, 1'b0, 64'h0000_0000_B60B_60B0, 1'b1);
        wait_valid("lat_backpressure");
        held = {res_hi, res_lo};
        check("bp_value", held, 64'h0000_0000_B60B_60B0);
        for (int i = 0; i < 10; i++) begin
            start_valid = (i == 3);
            op_a = 32'd1; op_b = 32'd1;
            @(posedge clk); #1;
            check("bp_hold", {res_hi, res_lo}, held);
            check("bp_flags", {61'b0, res_valid, start_ready, busy}, 64'h5);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {62'b0, res_valid, start_ready}, 64'h1);

        // Reset two cycles into CALC drops the in-flight product.
        issue(32'd5, 32'd5, 1'b0, 64'h0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        start_valid = 1'b1;
        @(posedge clk); #1;
        check("midrst_flags", {61'b0, busy, res_valid, start_ready}, 64'h0);
        check("midrst_result", {res_hi, res_lo}, 64'h0);
        start_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        issue(32'd6, 32'd7, 1'b0, 64'd42, 1'b1);
        wait_valid("lat_after_rst");
        @(posedge clk); #1;

        // MUL_CYCLES=1 instance: back-to-back random traffic, one op every 3 cycles.
        last_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] a, b;
            logic s;
            int n;
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            if (i == 0) begin a = 32'h8000_0000; b = 32'h8000_0000; s = 1'b1; end
            if (i == 1) begin a = 32'hFFFF_FFFF; b = 32'h0000_0001; s = 1'b1; end
            n = 0;
            while (!start_ready1 && n < 20) begin
                @(posedge clk); #1; n++;
            end
            if (!start_ready1) check("dut1_ready_timeout", 64'h0, 64'h1);
            op_a1 = a; op_b1 = b; is_signed1 = s; start_valid1 = 1'b1;
            exp_q1.push_back(ref_mul(a, b, s));
            @(posedge clk); #1;
            start_valid1 = 1'b0;
            if (i > 0) check("dut1_interval", 64'(cyc - last_acc), 64'd3);
            last_acc = cyc;
        end

        for (int n = 0; n < 100 && (exp_q0.size() != 0 || exp_q1.size() != 0); n++) begin
            @(posedge clk); #1;
        end
        check("drain_q0", 64'(exp_q0.size()), 64'h0);
        check("drain_q1", 64'(exp_q1.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
